// File: rtl/uart_alu_sequencer.sv
// Command sequencer between the UART RX/TX FIFOs and the ALU datapath.
// Collects operand A, operand B and opcode from the RX FIFO, validates the
// opcode, latches the ALU result and pushes it into the TX FIFO. Partial
// commands are abandoned after an inter-byte timeout counted in baud ticks.
module uart_alu_sequencer #(
  parameter int unsigned NB_DATA       = 8,
  parameter int unsigned NB_CODE       = 6,
  parameter int unsigned NB_TOUT       = 16,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_empty,
  input  logic [NB_DATA-1:0] i_rx_data,
  output logic               o_rx_rd,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_CODE-1:0] o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_full,
  output logic               o_tx_wr,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_op_err,
  output logic               o_timeout,
  output logic [7:0]         o_cmd_cnt
);

  typedef enum logic [2:0] {
    StGetA,
    StGetB,
    StGetOp,
    StExec,
    StSend
  } state_e;

  localparam logic [NB_CODE-1:0] OpAdd = NB_CODE'(6'b100000);
  localparam logic [NB_CODE-1:0] OpSub = NB_CODE'(6'b100010);
  localparam logic [NB_CODE-1:0] OpAnd = NB_CODE'(6'b100100);
  localparam logic [NB_CODE-1:0] OpOr  = NB_CODE'(6'b100101);
  localparam logic [NB_CODE-1:0] OpXor = NB_CODE'(6'b100110);
  localparam logic [NB_CODE-1:0] OpNor = NB_CODE'(6'b100111);
  localparam logic [NB_CODE-1:0] OpSra = NB_CODE'(6'b000011);
  localparam logic [NB_CODE-1:0] OpSrl = NB_CODE'(6'b000010);

  localparam logic [NB_TOUT-1:0] ToutLast = NB_TOUT'(TIMEOUT_TICKS - 1);

  state_e               state_q, state_d;
  logic [NB_DATA-1:0]   a_q, a_d;
  logic [NB_DATA-1:0]   b_q, b_d;
  logic [NB_CODE-1:0]   op_q, op_d;
  logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
  logic [7:0]           cmd_cnt_q, cmd_cnt_d;
  logic [NB_TOUT-1:0]   tout_q, tout_d;
  logic                 op_err_q, op_err_d;
  logic                 timeout_q, timeout_d;
  logic                 rx_rd, tx_wr;
  logic                 op_ok;
  logic                 tout_expire;

  // Opcode membership test on the byte currently at the RX FIFO head.
  always_comb begin
    op_ok = 1'b0;
    unique case (i_rx_data[NB_CODE-1:0])
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSra, OpSrl: op_ok = 1'b1;
      default:                                              op_ok = 1'b0;
    endcase
  end

  // Abort condition while waiting for a later byte; a pop in the same cycle wins.
  assign tout_expire = i_tick && (tout_q == ToutLast);

  // Next-state, capture and handshake logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    cmd_cnt_d = cmd_cnt_q;
    tout_d    = tout_q;
    op_err_d  = 1'b0;
    timeout_d = 1'b0;
    rx_rd     = 1'b0;
    tx_wr     = 1'b0;
    unique case (state_q)
      StGetA: begin
        tout_d = '0;
        if (!i_rx_empty) begin
          rx_rd   = 1'b1;
          a_d     = i_rx_data;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (!i_rx_empty) begin
          rx_rd   = 1'b1;
          b_d     = i_rx_data;
          tout_d  = '0;
          state_d = StGetOp;
        end else if (tout_expire) begin
          timeout_d = 1'b1;
          tout_d    = '0;
          state_d   = StGetA;
        end else if (i_tick) begin
          tout_d = tout_q + NB_TOUT'(1);
        end
      end
      StGetOp: begin
        if (!i_rx_empty) begin
          rx_rd  = 1'b1;
          op_d   = i_rx_data[NB_CODE-1:0];
          tout_d = '0;
          if (op_ok) begin
            state_d = StExec;
          end else begin
            op_err_d = 1'b1;
            state_d  = StGetA;
          end
        end else if (tout_expire) begin
          timeout_d = 1'b1;
          tout_d    = '0;
          state_d   = StGetA;
        end else if (i_tick) begin
          tout_d = tout_q + NB_TOUT'(1);
        end
      end
      StExec: begin
        tout_d    = '0;
        tx_data_d = i_alu_result;
        state_d   = StSend;
      end
      StSend: begin
        tout_d = '0;
        if (!i_tx_full) begin
          tx_wr     = 1'b1;
          cmd_cnt_d = cmd_cnt_q + 8'd1;
          state_d   = StGetA;
        end
      end
      default: begin
        tout_d  = '0;
        state_d = StGetA;
      end
    endcase
  end

  // State and registered outputs; reset discards any partial command.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= StGetA;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      tx_data_q <= '0;
      cmd_cnt_q <= '0;
      tout_q    <= '0;
      op_err_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      tx_data_q <= tx_data_d;
      cmd_cnt_q <= cmd_cnt_d;
      tout_q    <= tout_d;
      op_err_q  <= op_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_rx_rd   = rx_rd;
  assign o_tx_wr   = tx_wr;
  assign o_alu_a   = a_q;
  assign o_alu_b   = b_q;
  assign o_alu_op  = op_q;
  assign o_tx_data = tx_data_q;
  assign o_cmd_cnt = cmd_cnt_q;
  assign o_op_err  = op_err_q;
  assign o_timeout = timeout_q;
  assign o_busy    = (state_q != StGetA);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Scoreboard bench for uart_alu_sequencer: an RX FIFO model feeds bytes, a
// behavioural ALU computes expected results that a monitor compares on push.
module tb_uart_alu_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_tick;
  logic       i_rx_empty;
  logic [7:0] i_rx_data;
  logic       o_rx_rd;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       i_tx_full;
  logic       o_tx_wr;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_op_err;
  logic       o_timeout;
  logic [7:0] o_cmd_cnt;

  uart_alu_sequencer #(
    .NB_DATA      (8),
    .NB_CODE      (6),
    .NB_TOUT      (16),
    .TIMEOUT_TICKS(640)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_tick      (i_tick),
    .i_rx_empty  (i_rx_empty),
    .i_rx_data   (i_rx_data),
    .o_rx_rd     (o_rx_rd),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .i_alu_result(i_alu_result),
    .i_tx_full   (i_tx_full),
    .o_tx_wr     (o_tx_wr),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_op_err    (o_op_err),
    .o_timeout   (o_timeout),
    .o_cmd_cnt   (o_cmd_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural ALU (also serves as the reference for expected results).
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return sa >>> b;
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit is_valid(input logic [5:0] op);
    return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  endfunction

  always_comb i_alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  logic [7:0]  rxq[$];
  logic [7:0]  exp_q[$];
  int unsigned pop_cyc_q[$];
  int unsigned cyc = 0;
  int unsigned stim_checks = 0, stim_errors = 0;
  int unsigned mon_checks = 0, mon_errors = 0;
  int unsigned wr_seen = 0, err_seen = 0, tout_seen = 0;
  int unsigned last_wr_cyc = 0;
  logic [7:0]  last_wr_data = 8'h00;
  bit          rand_full = 1'b0;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Monitor: checks handshake rules, pulse widths and pushed data.
  initial begin
    logic       prev_err, prev_tout;
    logic [7:0] exp;
    prev_err  = 1'b0;
    prev_tout = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        mon_checks++;
        if (o_rx_rd && i_rx_empty) begin
          mon_errors++;
          $display("FAIL rx_pop_when_empty: rd=%0b empty=%0b required no pop", o_rx_rd,
                   i_rx_empty);
        end
        mon_checks++;
        if (o_tx_wr && i_tx_full) begin
          mon_errors++;
          $display("FAIL tx_push_when_full: wr=%0b full=%0b required no push", o_tx_wr,
                   i_tx_full);
        end
        if (o_tx_wr) begin
          wr_seen++;
          last_wr_cyc  = cyc;
          last_wr_data = o_tx_data;
          mon_checks++;
          if (exp_q.size() == 0) begin
            mon_errors++;
            $display("FAIL unexpected_push: data=%02h required no push", o_tx_data);
          end else begin
            exp = exp_q.pop_front();
            if (o_tx_data !== exp) begin
              mon_errors++;
              $display("FAIL tx_data: got %02h required %02h", o_tx_data, exp);
            end
          end
        end
        if (o_op_err) begin
          err_seen++;
          mon_checks++;
          if (prev_err) begin
            mon_errors++;
            $display("FAIL op_err_width: got 2+ cycles required 1");
          end
        end
        if (o_timeout) begin
          tout_seen++;
          mon_checks++;
          if (prev_tout) begin
            mon_errors++;
            $display("FAIL timeout_width: got 2+ cycles required 1");
          end
        end
        prev_err  = o_op_err;
        prev_tout = o_timeout;
      end else begin
        prev_err  = 1'b0;
        prev_tout = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    stim_checks++;
    if (act !== exp) begin
      stim_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    i_rx_empty = (rxq.size() == 0);
    i_rx_data  = (rxq.size() == 0) ? 8'h00 : rxq[0];
  endtask

  // One clock: sample pop request, let the edge happen, then update the FIFO model.
  task automatic cycle();
    logic rd_s;
    @(negedge i_clk);
    rd_s = o_rx_rd;
    if (rd_s && rxq.size() > 0) pop_cyc_q.push_back(cyc);
    @(posedge i_clk);
    #1;
    if (rd_s && rxq.size() > 0) void'(rxq.pop_front());
    i_tick = 1'b0;
    if (rand_full) i_tx_full = ($urandom_range(0, 3) == 0);
    refresh();
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rxq.push_back(a);
    rxq.push_back(b);
    rxq.push_back(op);
    if (is_valid(op[5:0])) exp_q.push_back(alu_model(a, b, op[5:0]));
    refresh();
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned n = 0;
    while ((rxq.size() != 0 || exp_q.size() != 0 || o_busy) && n < bound) begin
      cycle();
      n++;
    end
    if (n >= bound) chk("idle_wait_expired", n, 0);
  endtask

  initial begin
    int unsigned w0, e0, t0, drop_cyc;
    logic [5:0]  valid_ops [8];
    valid_ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    i_reset   = 1'b0;
    i_tick    = 1'b0;
    i_tx_full = 1'b0;
    refresh();

    // Reset state.
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_alu_a", o_alu_a, 0);
    chk("rst_alu_b", o_alu_b, 0);
    chk("rst_alu_op", o_alu_op, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_cmd_cnt", o_cmd_cnt, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_pulses", {o_op_err, o_timeout, o_tx_wr, o_rx_rd}, 0);
    i_reset = 1'b1;
    cycle();

    // ADD 5+3, back-to-back pops and 2-cycle latency to push.
    pop_cyc_q.delete();
    push_cmd(8'h05, 8'h03, 8'h20);
    wait_idle(50);
    chk("add_pop_count", pop_cyc_q.size(), 3);
    if (pop_cyc_q.size() == 3) begin
      chk("add_pops_consecutive", pop_cyc_q[2] - pop_cyc_q[0], 2);
      chk("add_push_latency", last_wr_cyc - pop_cyc_q[2], 2);
    end
    chk("add_push_count", wr_seen, 1);
    chk("add_result", last_wr_data, 8'h08);
    chk("add_cmd_cnt", o_cmd_cnt, 1);

    // OR under TX back-pressure.
    i_tx_full = 1'b1;
    w0 = wr_seen;
    push_cmd(8'hF0, 8'h0F, 8'h25);
    repeat (20) cycle();
    chk("full_no_push", wr_seen, w0);
    chk("full_pending", exp_q.size(), 1);
    chk("full_data_stable", o_tx_data, 8'hFF);
    chk("full_busy", o_busy, 1);
    i_tx_full = 1'b0;
    drop_cyc  = cyc;
    wait_idle(20);
    chk("full_push_on_drop", last_wr_cyc, drop_cyc);
    chk("or_result", last_wr_data, 8'hFF);
    chk("or_cmd_cnt", o_cmd_cnt, 2);

    // Invalid opcode then a valid SUB.
    w0 = wr_seen;
    e0 = err_seen;
    push_cmd(8'h01, 8'h02, 8'h3F);
    wait_idle(50);
    repeat (3) cycle();
    chk("inv_op_err_pulses", err_seen, e0 + 1);
    chk("inv_no_push", wr_seen, w0);
    chk("inv_cmd_cnt", o_cmd_cnt, 2);
    push_cmd(8'h07, 8'h02, 8'h22);
    wait_idle(50);
    chk("sub_result", last_wr_data, 8'h05);
    chk("sub_cmd_cnt", o_cmd_cnt, 3);

    // Timeout after one byte, tick every 4 cycles.
    t0 = tout_seen;
    rxq.push_back(8'hAA);
    refresh();
    cycle();
    chk("tout_busy_after_a", o_busy, 1);
    for (int n = 1; n <= 640; n++) begin
      repeat (3) cycle();
      i_tick = 1'b1;
      cycle();
      if (n == 639) begin
        chk("tout_not_early", {o_timeout, o_busy}, 2'b01);
      end
    end
    chk("tout_pulse", o_timeout, 1);
    chk("tout_back_to_idle", o_busy, 0);
    chk("tout_operand_held", o_alu_a, 8'hAA);
    cycle();
    chk("tout_count", tout_seen, t0 + 1);
    chk("tout_pulse_low", o_timeout, 0);
    push_cmd(8'h0C, 8'h0A, 8'h24);
    wait_idle(50);
    chk("and_after_tout", last_wr_data, 8'h08);
    chk("and_cmd_cnt", o_cmd_cnt, 4);

    // Pop coinciding with the final tick must win and clear the counter.
    t0 = tout_seen;
    rxq.push_back(8'h11);
    refresh();
    cycle();
    repeat (639) begin
      i_tick = 1'b1;
      cycle();
    end
    rxq.push_back(8'h22);
    refresh();
    i_tick = 1'b1;
    cycle();
    cycle();
    chk("coincide_no_tout", tout_seen, t0);
    chk("coincide_in_get_op", o_busy, 1);
    repeat (638) begin
      i_tick = 1'b1;
      cycle();
    end
    cycle();
    chk("coincide_cnt_cleared", tout_seen, t0);
    chk("coincide_still_busy", o_busy, 1);

    // Asynchronous reset in the middle of GET_OP.
    w0 = wr_seen;
    @(negedge i_clk);
    #2 i_reset = 1'b0;
    #1;
    chk("arst_operands", {o_alu_a, o_alu_b, 2'b00, o_alu_op}, 0);
    chk("arst_tx_data", o_tx_data, 0);
    chk("arst_cmd_cnt", o_cmd_cnt, 0);
    chk("arst_busy", o_busy, 0);
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b1;
    repeat (10) cycle();
    chk("arst_no_push", wr_seen, w0);
    chk("arst_idle", o_busy, 0);

    // 256 random valid commands with random back-pressure: counter wraps to 0.
    w0 = wr_seen;
    rand_full = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_cmd(8'($urandom), 8'($urandom), {2'b00, valid_ops[$urandom_range(0, 7)]});
      repeat ($urandom_range(0, 3)) cycle();
    end
    wait_idle(20000);
    rand_full = 1'b0;
    i_tx_full = 1'b0;
    cycle();
    chk("stream_push_count", wr_seen - w0, 256);
    chk("stream_cnt_wrap", o_cmd_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", stim_checks + mon_checks,
             stim_errors + mon_errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Command sequencer between the UART RX/TX FIFOs and the ALU datapath.
- Pops three bytes from the RX FIFO in order: operand A, operand B, opcode. Validates the opcode, presents the operands to the combinational ALU, registers the result and pushes it into the TX FIFO under full back-pressure.
- Aborts partial commands after an inter-byte timeout measured in baud ticks.
- Replaces ad-hoc RX-byte sniffing with proper FIFO handshakes.

Parameters:
- NB_DATA, 8, operand/result/byte width
- NB_CODE, 6, opcode width (low NB_CODE bits of the third byte)
- NB_TOUT, 16, timeout counter width
- TIMEOUT_TICKS, 640, baud ticks allowed between bytes of one command (about 4 char times at 16x oversampling)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_tick  in  1  baud-rate tick from the mod_m counter
- i_rx_empty  in  1  RX FIFO empty
- i_rx_data  in  NB_DATA  RX FIFO head word (first-word-fall-through, valid when not empty)
- o_rx_rd  out  1  RX FIFO pop
- o_alu_a  out  NB_DATA  operand A to ALU
- o_alu_b  out  NB_DATA  operand B to ALU
- o_alu_op  out  NB_CODE  opcode to ALU
- i_alu_result  in  NB_DATA  combinational ALU result
- i_tx_full  in  1  TX FIFO full
- o_tx_wr  out  1  TX FIFO push
- o_tx_data  out  NB_DATA  TX FIFO write data
- o_busy  out  1  high in any state other than GET_A
- o_op_err  out  1  one-cycle pulse: invalid opcode
- o_timeout  out  1  one-cycle pulse: command aborted on timeout
- o_cmd_cnt  out  8  completed commands, wraps 255 to 0

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=GET_A.
  - o_alu_a, o_alu_b, o_alu_op, o_tx_data and o_cmd_cnt are 0.
  - The timeout counter is 0.
  - Pulses are low.
  - Reset mid-command discards all captured bytes. No push occurs.
- States: GET_A, GET_B, GET_OP, EXEC, SEND.
- Pop rule:
  - In the GET_* states, o_rx_rd = !i_rx_empty (combinational).
  - The byte is captured into the state's register on that same edge, and the state advances.
  - At most one pop per cycle. Never pop in EXEC or SEND. Never pop when empty.
- GET_A to GET_B to GET_OP on each pop. The GET_OP pop loads o_alu_op = i_rx_data[NB_CODE-1:0].
- Opcode check at the GET_OP pop:
  - Valid set: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL.
  - Valid opcode: go to EXEC.
  - Invalid opcode: o_op_err is pulsed in the next cycle and the state returns to GET_A. No push, and o_cmd_cnt is unchanged.
- EXEC (1 cycle): o_tx_data <= i_alu_result, then go to SEND.
- SEND:
  - o_tx_wr = !i_tx_full (combinational); o_tx_data is stable.
  - On the push edge: o_cmd_cnt increments and the state returns to GET_A.
  - If full, stay in SEND indefinitely. There is no timeout in SEND.
- Latency: the op byte is popped at edge k, o_tx_wr is high in cycle k+1 to k+2, and the push takes effect at edge k+2 when the TX FIFO is not full.
- Timeout:
  - The counter runs only in GET_B and GET_OP. It increments on i_tick and is cleared on every pop and on entry to GET_A.
  - When the counter reaches TIMEOUT_TICKS-1 and i_tick is high with no pop in that cycle, the command aborts: o_timeout pulses for 1 cycle, the state goes to GET_A and the counter clears.
  - Pop and tick in the same cycle: the pop wins and the counter clears.
  - GET_A never times out.
- Operand registers hold their last value between commands. They are not cleared on abort, except by reset.
- Back-to-back commands: the next GET_A pop can occur in the cycle after the push edge.

Test Plan:
- RX FIFO preloaded 0x05, 0x03, 0x20 (ADD), TX not full -> o_rx_rd is high in 3 consecutive cycles; o_tx_wr pulses once with o_tx_data=0x08 (bench ALU model) exactly 2 cycles after the op pop; o_cmd_cnt=1.
- Bytes 0xF0, 0x0F, 0x25 (OR) with i_tx_full=1 for 20 cycles -> SEND holds, o_tx_wr stays 0, data stable at 0xFF; push happens the cycle full drops.
- Bytes 0x01, 0x02, 0x3F (invalid) -> o_op_err is a single pulse; no o_tx_wr; next bytes 0x07, 0x02, 0x22 give 0x05.
- Send only 0xAA, then leave the FIFO empty with i_tick every 4 cycles -> o_timeout pulses at the 640th tick; state returns to GET_A; a following full command executes correctly.
- Pop coinciding with tick at count TIMEOUT_TICKS-1 -> no timeout, counter cleared; assert reset low mid-GET_OP -> all outputs 0 asynchronously, no push after release.
- Stream of 256 valid commands -> o_cmd_cnt wraps to 0; RX empty never popped (assertion: o_rx_rd implies !i_rx_empty; o_tx_wr implies !i_tx_full).
